stream_arb_mux2: RTL

- Upstream selection stage that produces the select and data consumed by the team's 2:1 mux datapath.
- Arbitrates two valid/ready packet streams onto one output using packet-locked round-robin.
- Registers the chosen beat together with the select that chose it, so downstream sees data, last flag and select aligned.
- Keeps wrapping per-channel completed-packet counters for debug.

---
 rtl/stream_arb_mux2_pkg.sv | 22 ++
 rtl/stream_arb_mux2_arb_rr2.sv | 90 +++++++++
 rtl/stream_arb_mux2.sv | 113 +++++++++++
 3 files changed

// File: rtl/stream_arb_mux2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_arb_mux2_pkg
//  Purpose  : Shared types and constants for the two-stream arbiter and the
//             downstream 2:1 mux datapath that consumes its select.
//  Contents : arb_state_e  - arbiter state (IDLE / LOCK0 / LOCK1), 2-bit
//             SEL_CH0/1    - select encoding shared with the downstream mux
//  Revision : 1.0 - initial release
// ============================================================================
package stream_arb_mux2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

endpackage : stream_arb_mux2_pkg
`default_nettype wire

// File: rtl/stream_arb_mux2_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : stream_arb_mux2_arb_rr2
//  Purpose  : Packet-locked round-robin arbiter for two valid/ready streams.
//             Holds the lock state and tie-break priority, generates the
//             per-channel readies and a transfer strobe with the granted
//             channel and its last flag.
//  Ports    : clk, rst            - clock, async active-high reset
//             i_in0/1_valid       - channel beat valid
//             i_in0/1_last        - channel final beat of packet
//             i_load_en           - output register can take a beat
//             o_in0/1_ready       - channel beat accepted when valid
//             o_xfer              - a beat transfers on this edge
//             o_grant             - channel of that beat
//             o_xfer_last         - last flag of that beat
//  Revision : 1.0 - initial release
// ============================================================================
module stream_arb_mux2_arb_rr2
    import stream_arb_mux2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_in0_valid,
    input  logic i_in0_last,
    input  logic i_in1_valid,
    input  logic i_in1_last,
    input  logic i_load_en,
    output logic o_in0_ready,
    output logic o_in1_ready,
    output logic o_xfer,
    output logic o_grant,
    output logic o_xfer_last
);

    arb_state_e r_state;
    logic       r_prio;

    logic w_rdy0;
    logic w_rdy1;
    logic w_xfer0;
    logic w_xfer1;

    // A channel's ready never looks at its own valid: in IDLE it only
    // depends on whether the competitor is asking and who holds priority.
    // With neither channel valid both readies may be high; nothing moves.
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy0 = !i_in1_valid || (r_prio == SEL_CH0);
                w_rdy1 = !i_in0_valid || (r_prio == SEL_CH1);
            end
            ST_LOCK0: w_rdy0 = 1'b1;
            ST_LOCK1: w_rdy1 = 1'b1;
            default: begin
                w_rdy0 = 1'b0;
                w_rdy1 = 1'b0;
            end
        endcase
    end

    assign o_in0_ready = w_rdy0 & i_load_en & ~rst;
    assign o_in1_ready = w_rdy1 & i_load_en & ~rst;

    assign w_xfer0     = i_in0_valid & o_in0_ready;
    assign w_xfer1     = i_in1_valid & o_in1_ready;
    assign o_xfer      = w_xfer0 | w_xfer1;
    assign o_grant     = w_xfer1 ? SEL_CH1 : SEL_CH0;
    assign o_xfer_last = w_xfer1 ? i_in1_last : i_in0_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= SEL_CH0;
        end else if (o_xfer) begin
            if (o_xfer_last) begin
                r_state <= ST_IDLE;
                r_prio  <= ~o_grant;
            end else begin
                r_state <= (o_grant == SEL_CH1) ? ST_LOCK1 : ST_LOCK0;
            end
        end else if (!(r_state inside {ST_IDLE, ST_LOCK0, ST_LOCK1})) begin
            // Unreachable encoding: recover rather than deadlock both readies.
            r_state <= ST_IDLE;
        end
    end

endmodule : stream_arb_mux2_arb_rr2
`default_nettype wire

// File: rtl/stream_arb_mux2.sv
`default_nettype none
// ============================================================================
//  Module   : stream_arb_mux2
//  Purpose  : Arbitrates two valid/ready packet streams onto one registered
//             output using packet-locked round-robin. The chosen beat is
//             registered together with its select so data, last and select
//             stay aligned downstream. Wrapping per-channel completed-packet
//             counters are kept for debug.
//  Ports    : clk, rst                          - clock, async high reset
//             in0_valid/ready/data/last         - channel 0 stream
//             in1_valid/ready/data/last         - channel 1 stream
//             out_valid/ready/data/last/select  - registered output stream
//             pkt_cnt0, pkt_cnt1                - completed packet counts
//  Revision : 1.0 - initial release
// ============================================================================
module stream_arb_mux2
    import stream_arb_mux2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_select,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              w_load_en;
    logic              w_xfer;
    logic              w_grant;
    logic              w_last;
    logic [DATA_W-1:0] w_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_select;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    // Single output register: it can load when empty or being drained.
    assign w_load_en = !r_out_valid || out_ready;

    stream_arb_mux2_arb_rr2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_in0_valid (in0_valid),
        .i_in0_last  (in0_last),
        .i_in1_valid (in1_valid),
        .i_in1_last  (in1_last),
        .i_load_en   (w_load_en),
        .o_in0_ready (in0_ready),
        .o_in1_ready (in1_ready),
        .o_xfer      (w_xfer),
        .o_grant     (w_grant),
        .o_xfer_last (w_last)
    );

    assign w_data = (w_grant == SEL_CH1) ? in1_data : in0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_select <= SEL_CH0;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_data;
            r_out_last   <= w_last;
            r_out_select <= w_grant;
        end else if (w_load_en) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_xfer && w_last) begin
            if (w_grant == SEL_CH1) begin
                r_cnt1 <= r_cnt1 + c_CNT_ONE;
            end else begin
                r_cnt0 <= r_cnt0 + c_CNT_ONE;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign out_select = r_out_select;
    assign pkt_cnt0   = r_cnt0;
    assign pkt_cnt1   = r_cnt1;

endmodule : stream_arb_mux2
`default_nettype wire
